// File: rtl/axi_lite_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_master_if : command/response handshake plus AXI4-Lite master bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface axi_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [1:0]        rsp_resp;
  logic [DATA_W-1:0] rsp_rdata;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_resp, rsp_rdata,
    input  rsp_ready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_resp, rsp_rdata,
    output rsp_ready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_master : single-outstanding AXI4-Lite initiator, one beat per command
// Rev 1.0
// ---------------------------------------------------------------------------
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  axi_lite_master_if.master bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_REQ  = 3'd1,
    W_RESP = 3'd2,
    R_REQ  = 3'd3,
    R_DATA = 3'd4,
    RSP    = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              wr;
  logic              aw_done;
  logic              w_done;
  logic              aw_fin;
  logic              w_fin;

  assign bus.awaddr = addr;
  assign bus.araddr = addr;
  assign bus.wdata  = wdata_q;
  assign bus.wstrb  = wstrb_q;

  // A channel counts as finished if it handshook earlier or is handshaking now
  assign aw_fin = aw_done | (bus.awvalid & bus.awready);
  assign w_fin  = w_done  | (bus.wvalid  & bus.wready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wr            <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.awvalid   <= 1'b0;
      bus.wvalid    <= 1'b0;
      bus.bready    <= 1'b0;
      bus.arvalid   <= 1'b0;
      bus.rready    <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_resp  <= 2'b00;
      bus.rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_ready && bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            addr          <= bus.cmd_addr;
            wdata_q       <= bus.cmd_wdata;
            wstrb_q       <= bus.cmd_wstrb;
            wr            <= bus.cmd_write;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            if (bus.cmd_write) begin
              bus.awvalid <= 1'b1;
              bus.wvalid  <= 1'b1;
              state       <= W_REQ;
            end else begin
              bus.arvalid <= 1'b1;
              state       <= R_REQ;
            end
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end

        W_REQ: begin
          if (bus.awvalid && bus.awready) begin
            bus.awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (bus.wvalid && bus.wready) begin
            bus.wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bus.bready <= 1'b1;
            state      <= W_RESP;
          end
        end

        W_RESP: begin
          if (bus.bvalid && bus.bready) begin
            bus.bready    <= 1'b0;
            bus.rsp_resp  <= bus.bresp;
            bus.rsp_rdata <= '0;
            bus.rsp_write <= wr;
            bus.rsp_valid <= 1'b1;
            state         <= RSP;
          end
        end

        R_REQ: begin
          if (bus.arvalid && bus.arready) begin
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
            state       <= R_DATA;
          end
        end

        R_DATA: begin
          if (bus.rvalid && bus.rready) begin
            bus.rready    <= 1'b0;
            bus.rsp_resp  <= bus.rresp;
            bus.rsp_rdata <= bus.rdata;
            bus.rsp_write <= wr;
            bus.rsp_valid <= 1'b1;
            state         <= RSP;
          end
        end

        RSP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_lite_master : randomized scoreboard bench with a memory-backed AXI slave
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_axi_lite_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  axi_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;

  rsp_t        exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  // per-transaction slave / consumer behaviour
  int          aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0, rsp_d = 0;
  logic [1:0]  slv_resp = 2'b00;
  logic [31:0] cur_addr = '0, cur_data = '0;
  logic [3:0]  cur_strb = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Slave: each channel counts its wait states, then raises ready for one cycle
  initial begin
    int aw_ph, w_ph, ar_ph, b_ph, r_ph, aw_c, w_c, ar_c, b_c, r_c;
    logic [31:0] aw_a, w_dat, ar_a, m;
    logic [3:0]  w_s;
    aw_ph = 0; w_ph = 0; ar_ph = 0; b_ph = 0; r_ph = 0;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    aw_a = '0; w_dat = '0; ar_a = '0; w_s = '0;
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_ph = 0; w_ph = 0; ar_ph = 0; b_ph = 0; r_ph = 0;
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        bus.bvalid = 0; bus.rvalid = 0;
      end else begin
        if (aw_ph == 0 && bus.awvalid) begin
          aw_ph = 1; aw_a = bus.awaddr; aw_c = aw_d;
          check("awaddr", aw_a, cur_addr);
        end else if (aw_ph == 1) check("aw_stable", {bus.awvalid, bus.awaddr}, {1'b1, aw_a});
        else if (aw_ph == 2) begin check("awvalid_drop", bus.awvalid, 0); aw_ph = 3; end
        if (aw_ph == 1) begin
          if (aw_c == 0) begin bus.awready = 1; aw_ph = 2; end
          else begin bus.awready = 0; aw_c--; end
        end else bus.awready = 0;

        if (w_ph == 0 && bus.wvalid) begin
          w_ph = 1; w_dat = bus.wdata; w_s = bus.wstrb; w_c = w_d;
          check("wdata_wstrb", {bus.wstrb, bus.wdata}, {cur_strb, cur_data});
        end else if (w_ph == 1) check("w_stable", {bus.wvalid, bus.wstrb, bus.wdata}, {1'b1, w_s, w_dat});
        else if (w_ph == 2) begin check("wvalid_drop", bus.wvalid, 0); w_ph = 3; end
        if (w_ph == 1) begin
          if (w_c == 0) begin bus.wready = 1; w_ph = 2; end
          else begin bus.wready = 0; w_c--; end
        end else bus.wready = 0;

        if (bus.bready && b_ph != 3) check("bready_after_aw_w", (aw_ph == 3 && w_ph == 3), 1);
        if (b_ph == 3) begin
          check("bready_drop", bus.bready, 0);
          bus.bvalid = 0; b_ph = 0; aw_ph = 0; w_ph = 0;
        end else if (aw_ph == 3 && w_ph == 3) begin
          if (b_ph == 0) begin b_c = b_d; b_ph = 1; end
          if (b_ph == 1) begin
            if (b_c == 0) begin bus.bvalid = 1; bus.bresp = slv_resp; b_ph = 2; end
            else b_c--;
          end
          if (b_ph == 2 && bus.bready) begin
            if (slv_resp == 2'b00) begin
              m = slv_mem.exists(aw_a) ? slv_mem[aw_a] : 32'h0;
              for (int b = 0; b < 4; b++) if (w_s[b]) m[8*b +: 8] = w_dat[8*b +: 8];
              slv_mem[aw_a] = m;
            end
            b_ph = 3;
          end
        end

        if (ar_ph == 0 && bus.arvalid) begin
          ar_ph = 1; ar_a = bus.araddr; ar_c = ar_d;
          check("araddr", ar_a, cur_addr);
        end else if (ar_ph == 1) check("ar_stable", {bus.arvalid, bus.araddr}, {1'b1, ar_a});
        else if (ar_ph == 2) begin check("arvalid_drop", bus.arvalid, 0); ar_ph = 3; end
        if (ar_ph == 1) begin
          if (ar_c == 0) begin bus.arready = 1; ar_ph = 2; end
          else begin bus.arready = 0; ar_c--; end
        end else bus.arready = 0;

        if (bus.rready && r_ph != 3) check("rready_after_ar", ar_ph == 3, 1);
        if (r_ph == 3) begin
          check("rready_drop", bus.rready, 0);
          bus.rvalid = 0; r_ph = 0; ar_ph = 0;
        end else if (ar_ph == 3) begin
          if (r_ph == 0) begin r_c = r_d; r_ph = 1; end
          if (r_ph == 1) begin
            if (r_c == 0) begin
              bus.rvalid = 1; bus.rresp = slv_resp;
              bus.rdata  = slv_mem.exists(ar_a) ? slv_mem[ar_a] : 32'h0;
              r_ph = 2;
            end else r_c--;
          end
          if (r_ph == 2 && bus.rready) r_ph = 3;
        end
      end
    end
  end

  // Monitor: consumes responses after rsp_d stall cycles and checks them against the queue
  initial begin
    int ph, c;
    rsp_t e;
    logic [34:0] hold;
    ph = 0; c = 0; hold = '0;
    bus.rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ph = 0; bus.rsp_ready = 0;
      end else if (ph == 2) begin
        check("rsp_valid_drop", bus.rsp_valid, 0);
        ph = 0; bus.rsp_ready = 0;
      end else if (bus.rsp_valid) begin
        if (ph == 0) begin
          ph = 1; c = rsp_d; hold = {bus.rsp_write, bus.rsp_resp, bus.rsp_rdata};
        end else begin
          check("rsp_stable", {bus.rsp_write, bus.rsp_resp, bus.rsp_rdata}, hold);
          check("cmd_ready_busy", bus.cmd_ready, 0);
        end
        if (c == 0) begin
          bus.rsp_ready = 1; ph = 2; n_rsp++;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_rsp: actual write=%0d resp=%0d rdata=0x%0h required none",
                     bus.rsp_write, bus.rsp_resp, bus.rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            check("rsp_write", bus.rsp_write, e.wr);
            check("rsp_resp", bus.rsp_resp, e.resp);
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
          end
        end else begin
          bus.rsp_ready = 0; c--;
        end
      end else begin
        bus.rsp_ready = 0;
      end
    end
  end

  // Reference model: predict the response from plain memory semantics, then present the command
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] resp, input bit expect_rsp);
    rsp_t e;
    logic [31:0] m;
    int k;
    slv_resp = resp; cur_addr = a; cur_data = d; cur_strb = s;
    if (expect_rsp) begin
      m = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
      e.wr = wr; e.resp = resp;
      if (wr) begin
        e.rdata = 32'h0;
        if (resp == 2'b00) begin
          for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
          ref_mem[a] = m;
        end
      end else e.rdata = m;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_wstrb = s;
    k = 0;
    while (!bus.cmd_ready && k < 200) begin @(negedge clk); k++; end
    check("cmd_accept", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !bus.cmd_ready) && k < 500) begin @(negedge clk); k++; end
    check("drain_in_time", k < 500, 1);
  endtask

  task automatic count_valids(input int n, output int naw, output int nw, output int nar);
    naw = 0; nw = 0; nar = 0;
    for (int i = 0; i < n; i++) begin
      naw += int'(bus.awvalid); nw += int'(bus.wvalid); nar += int'(bus.arvalid);
      @(negedge clk);
    end
  endtask

  initial begin
    int naw, nw, nar, rsp_before;
    logic [1:0] r;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.cmd_wstrb = 0;

    // reset state
    #12;
    check("reset_outputs", {bus.cmd_ready, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
                            bus.rready, bus.rsp_valid, bus.rsp_write, bus.rsp_resp}, 0);
    check("reset_rdata", bus.rsp_rdata, 0);
    @(negedge clk); rst_n = 1;
    #1 check("cmd_ready_at_release", bus.cmd_ready, 0);
    @(negedge clk);
    check("cmd_ready_after_release", bus.cmd_ready, 1);

    // write to a zero-wait slave
    issue(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 1'b1);
    count_valids(6, naw, nw, nar);
    check("t1_aw_cycles", naw, 1);
    check("t1_w_cycles", nw, 1);
    drain();

    // read back
    issue(1'b0, 32'h04, 32'h0, 4'h0, 2'b00, 1'b1);
    count_valids(6, naw, nw, nar);
    check("t2_ar_cycles", nar, 1);
    drain();

    // AW stalled 3 cycles while W is accepted immediately
    aw_d = 3;
    issue(1'b1, 32'h08, 32'h12345678, 4'h5, 2'b00, 1'b1);
    count_valids(10, naw, nw, nar);
    check("t3_aw_cycles", naw, 4);
    check("t3_w_cycles", nw, 1);
    drain();
    aw_d = 0;

    // consumer stalls 5 cycles; a stray command pulse must be ignored
    rsp_d = 5;
    rsp_before = n_rsp;
    issue(1'b0, 32'h08, 32'h0, 4'h0, 2'b00, 1'b1);
    begin
      int k;
      k = 0;
      while (!bus.rsp_valid && k < 50) begin @(negedge clk); k++; end
      check("t4_rsp_seen", bus.rsp_valid, 1);
    end
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 32'h30; bus.cmd_wdata = 32'hBAD0BAD0;
    bus.cmd_wstrb = 4'hF;
    @(negedge clk);
    bus.cmd_valid = 0;
    drain();
    repeat (10) @(negedge clk);
    check("t4_one_response", n_rsp - rsp_before, 1);
    rsp_d = 0;

    // SLVERR on a read is passed through
    issue(1'b0, 32'h1C, 32'h0, 4'h0, 2'b10, 1'b1);
    drain();
    check("t5_idle_after_err", {bus.cmd_ready, bus.rsp_valid}, 2'b10);

    // reset while a write waits for AW
    aw_d = 20;
    issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 2'b00, 1'b0);
    check("t6_in_w_req", bus.awvalid, 1);
    #2 rst_n = 0;
    #1 check("t6_async_clear", {bus.awvalid, bus.wvalid, bus.bready, bus.rsp_valid, bus.cmd_ready}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    aw_d = 0;
    #1 check("t6_ready_at_release", bus.cmd_ready, 0);
    @(negedge clk);
    check("t6_ready_after_release", bus.cmd_ready, 1);
    check("t6_no_rsp", bus.rsp_valid, 0);
    issue(1'b1, 32'h24, 32'hA5A5A5A5, 4'hF, 2'b00, 1'b1);
    drain();
    issue(1'b0, 32'h24, 32'h0, 4'h0, 2'b00, 1'b1);
    drain();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      aw_d  = $urandom_range(0, 3);
      w_d   = $urandom_range(0, 3);
      b_d   = $urandom_range(0, 3);
      ar_d  = $urandom_range(0, 3);
      r_d   = $urandom_range(0, 3);
      rsp_d = $urandom_range(0, 2);
      r = 2'b00;
      if ($urandom_range(0, 5) == 0) r = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, 32'($urandom),
            4'($urandom_range(0, 15)), r, 1'b1);
      drain();
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
